// File: rtl/matmul_result_reader.sv
// Streams the captured N x M product matrix from the systolic array out one element per beat,
// row-major, with per-element overflow flags and a sticky in-region overflow summary.
module matmul_result_reader #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BUS_WIDTH  = 16
) (
  input  logic                                                    clk_i,
  input  logic                                                    rst_i,
  input  logic                                                    capture_i,
  input  logic [1:0]                                              n_dim_i,
  input  logic [1:0]                                              m_dim_i,
  input  logic [(BUS_WIDTH/DATA_WIDTH)**2*2*DATA_WIDTH-1:0]       c_matrix_i,
  input  logic [(BUS_WIDTH/DATA_WIDTH)**2-1:0]                    flags_i,
  input  logic                                                    ready_i,
  output logic                                                    valid_o,
  output logic [2*DATA_WIDTH-1:0]                                 data_o,
  output logic [1:0]                                              row_o,
  output logic [1:0]                                              col_o,
  output logic                                                    ovf_o,
  output logic                                                    last_o,
  output logic                                                    busy_o,
  output logic                                                    done_o,
  output logic                                                    overflow_o
);

  localparam int unsigned MAX_DIM  = BUS_WIDTH / DATA_WIDTH;
  localparam int unsigned NUM_ELEM = MAX_DIM * MAX_DIM;
  localparam int unsigned ELEM_W   = 2 * DATA_WIDTH;

  typedef enum logic [1:0] {StIdle, StSend, StDone} state_e;

  state_e                       state_q, state_d;
  logic [NUM_ELEM*ELEM_W-1:0]   cmat_q;
  logic [NUM_ELEM-1:0]          flags_q;
  logic [1:0]                   n_q, m_q, r_q, c_q;
  logic                         overflow_q;

  logic [1:0]                   n_clamp, m_clamp;
  logic                         region_ovf;
  logic [ELEM_W-1:0]            elem;
  logic                         elem_ovf;
  logic                         send, transfer, col_last, row_last, is_last;

  // Zero or oversized dimensions fall back to the full array.
  function automatic logic [1:0] clamp_dim(input logic [1:0] d);
    if (d == 2'd0 || 32'(d) > MAX_DIM) return 2'(MAX_DIM);
    return d;
  endfunction

  always_comb begin
    n_clamp    = clamp_dim(n_dim_i);
    m_clamp    = clamp_dim(m_dim_i);
    region_ovf = 1'b0;
    for (int unsigned r = 0; r < MAX_DIM; r++) begin
      for (int unsigned c = 0; c < MAX_DIM; c++) begin
        if (r < 32'(n_clamp) && c < 32'(m_clamp)) region_ovf = region_ovf | flags_i[r*MAX_DIM+c];
      end
    end
  end

  // Mux by comparison so a row index one past the region never selects out of range.
  always_comb begin
    elem     = '0;
    elem_ovf = 1'b0;
    for (int unsigned e = 0; e < NUM_ELEM; e++) begin
      if (32'(r_q) * MAX_DIM + 32'(c_q) == e) begin
        elem     = cmat_q[e*ELEM_W +: ELEM_W];
        elem_ovf = flags_q[e];
      end
    end
  end

  assign send     = (state_q == StSend);
  assign transfer = send && ready_i;
  assign col_last = (c_q == m_q - 2'd1);
  assign row_last = (r_q == n_q - 2'd1);
  assign is_last  = col_last && row_last;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (capture_i) state_d = StSend;
      StSend:  if (transfer && is_last) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cmat_q     <= '0;
      flags_q    <= '0;
      n_q        <= '0;
      m_q        <= '0;
      r_q        <= '0;
      c_q        <= '0;
      overflow_q <= 1'b0;
    end else if (state_q == StIdle && capture_i) begin
      cmat_q     <= c_matrix_i;
      flags_q    <= flags_i;
      n_q        <= n_clamp;
      m_q        <= m_clamp;
      r_q        <= '0;
      c_q        <= '0;
      overflow_q <= region_ovf;
    end else if (transfer) begin
      if (col_last) begin
        c_q <= '0;
        r_q <= r_q + 2'd1;
      end else begin
        c_q <= c_q + 2'd1;
      end
    end
  end

  assign valid_o    = send;
  assign data_o     = send ? elem : '0;
  assign row_o      = send ? r_q : 2'd0;
  assign col_o      = send ? c_q : 2'd0;
  assign ovf_o      = send && elem_ovf;
  assign last_o     = send && is_last;
  assign busy_o     = (state_q != StIdle);
  assign done_o     = (state_q == StDone);
  assign overflow_o = overflow_q;

endmodule
